// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : State encodings and counter sizing shared by the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Bit counter only needs to reach WIDTH-1 before the FSM leaves SHIFT.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : structuralFullAdder
// Description : Single-bit full adder built from two half-adder stages.
// Revision    : 1.0 - initial release
// ============================================================================
module structuralFullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_carryin,
    output logic o_sum,
    output logic o_carryout
);

    logic w_axb;
    logic w_ab;
    logic w_prop;

    assign w_axb      = i_a ^ i_b;
    assign w_ab       = i_a & i_b;
    assign w_prop     = w_axb & i_carryin;
    assign o_sum      = w_axb ^ i_carryin;
    assign o_carryout = w_ab | w_prop;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, LSB first, one full adder per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int               CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_carry_msb;
    logic             r_carryout;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_accept;
    logic             w_last;

    structuralFullAdder u_fa (
        .i_a        (r_opa[0]),
        .i_b        (r_opb[0]),
        .i_carryin  (r_carry),
        .o_sum      (w_fa_sum),
        .o_carryout (w_fa_cout)
    );

    // DONE accepts a new start just like IDLE so additions can run back to back.
    assign w_accept = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_last   = (r_state == c_ST_SHIFT) && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:  w_next = start  ? c_ST_SHIFT : c_ST_IDLE;
            c_ST_SHIFT: w_next = w_last ? c_ST_DONE  : c_ST_SHIFT;
            c_ST_DONE:  w_next = start  ? c_ST_SHIFT : c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_ST_SHIFT);
        done = (r_state == c_ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opa       <= '0;
            r_opb       <= '0;
            r_sreg      <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_carry_msb <= 1'b0;
            r_carryout  <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= carryin;
            r_cnt   <= '0;
        end else if (r_state == c_ST_SHIFT) begin
            r_sreg  <= {w_fa_sum, r_sreg[WIDTH-1:1]};
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + c_ONE;
            // Published result only changes here, so it holds through DONE and IDLE.
            if (w_last) begin
                r_carry_msb <= r_carry;
                r_sum       <= {w_fa_sum, r_sreg[WIDTH-1:1]};
                r_carryout  <= w_fa_cout;
            end
        end
    end

    assign sum      = r_sum;
    assign carryout = r_carryout;
    assign overflow = r_carry_msb ^ r_carryout;

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one instance of the team's single-bit full adder.
- Latches two operands and a carry-in on start, then feeds the full adder one bit pair per clock, LSB first.
- Carries the ripple through a carry flip-flop and assembles the sum in a shift register.
- Downstream consumers receive sum, carryout and signed overflow with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only when not busy.
- a  input  WIDTH  operand A, captured on an accepted start.
- b  input  WIDTH  operand B, captured on an accepted start.
- carryin  input  1  carry into bit 0, captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- carryout  output  1  carry out of bit WIDTH-1; held with sum.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB); held with sum.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, sum=0, carryout=0, overflow=0; internal operand, carry and bit-count registers=0.
- Reset dominance: reset wins over every other input in the same cycle. A reset mid-operation aborts the addition, produces no done pulse, and clears the outputs.
- IDLE state:
  - start=1 captures a, b and carryin into the shift registers and carry flip-flop, clears the bit counter, and moves to SHIFT.
  - busy rises on the next cycle.
- SHIFT state, once per cycle:
  - The full adder consumes opA[0], opB[0] and the carry flip-flop.
  - The sum bit shifts into the MSB of the sum register, which shifts right.
  - opA and opB shift right; the carry flip-flop takes the full-adder carryout.
  - The counter increments.
  - When the counter reaches WIDTH-1, the pre-update carry flip-flop (carry into the MSB) is saved for overflow.
  - After the WIDTH-th bit, the block moves to DONE.
- DONE state:
  - Lasts exactly one cycle: done=1, busy=0.
  - sum, carryout and overflow are valid here and hold until the next accepted start.
  - Next state is IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
- Latency: start accepted at edge 0 gives busy=1 for cycles 1..WIDTH and done=1 in cycle WIDTH+1. Throughput is one addition per WIDTH+1 cycles.
- start while busy=1 is ignored; operands are not re-captured.
- Changes on a, b or carryin after capture have no effect.
- Arithmetic: {carryout,sum} = a + b + carryin, unsigned, modulo 2^(WIDTH+1). overflow is meaningful for two's-complement interpretation.
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a counter-width constant, $clog2(WIDTH).
- Sub-module: one instance of the existing structuralFullAdder is the datapath. The FSM, counter and shift registers stay in serial_adder.

Test Plan:
- a=8'h05, b=8'h03, carryin=0, start pulse -> done in cycle 9 after start; sum=8'h08, carryout=0, overflow=0.
- a=8'hFF, b=8'h01, carryin=0 -> sum=8'h00, carryout=1, overflow=0; a=8'h00, b=8'h00, carryin=1 -> sum=8'h01, carryout=0.
- a=8'h7F, b=8'h01, carryin=0 -> sum=8'h80, overflow=1, carryout=0; a=8'h80, b=8'h80 -> sum=8'h00, carryout=1, overflow=1.
- start re-asserted with a=8'hAA during busy after starting with 8'h10+8'h20 -> ignored; result sum=8'h30 at the original done time.
- reset asserted at busy cycle 4 -> next cycle busy=0, sum=0, no done pulse; a fresh start then yields a correct result.
- start held high across DONE with new operands 8'h0F+8'h01 -> second addition begins immediately; sum=8'h10 exactly 9 cycles after the first done.
